// File: rtl/cfg_discovery_pkg.sv
// Shared types and decode helpers for the configuration discovery responder.
// The build-time macro CFG_DISCOVERY_PARITY_EN adds a per-response parity bit
// in the top and FIFO; nothing in this package depends on it.
package cfg_discovery_pkg;

   localparam int unsigned CFG_IDX_MAGIC  = 0;
   localparam int unsigned CFG_IDX_LEN    = 1;
   localparam int unsigned CFG_IDX_ISA    = 2;
   localparam int unsigned CFG_IDX_ICACHE = 3;
   localparam int unsigned CFG_IDX_DCACHE = 4;
   localparam int unsigned CFG_IDX_CORE   = 5;
   localparam int unsigned CFG_IDX_BP     = 6;
   localparam int unsigned CFG_IDX_TLB    = 7;
   localparam int unsigned CFG_IDX_CNT    = 8;

   localparam logic [63:0] CFG_MAGIC = 64'hC0F1_6000_0000_0001;

   // Widest transaction id the response storage can carry.
   localparam int unsigned CFG_ID_W = 16;

   // Subset of the core configuration that software can discover.
   typedef struct packed {
      int unsigned xlen;
      int unsigned vlen;
      logic        rvf;
      logic        rvd;
      logic        rva;
      logic        rvb;
      logic        rvv;
      logic        rvc;
      logic        rvh;
      logic        rvzcb;
      logic        rvzcmp;
      logic        rvzicond;
      logic        rvs;
      logic        rvu;
      logic        mmu_present;
      logic        debug_en;
      int unsigned icache_byte_size;
      int unsigned icache_set_assoc;
      int unsigned icache_line_width;
      int unsigned dcache_byte_size;
      int unsigned dcache_set_assoc;
      int unsigned dcache_line_width;
      int unsigned nr_pmp_entries;
      int unsigned nr_sb_entries;
      int unsigned nr_commit_ports;
      int unsigned nr_load_buf_entries;
      int unsigned ras_depth;
      int unsigned btb_entries;
      int unsigned bht_entries;
      int unsigned itlb_entries;
      int unsigned dtlb_entries;
      int unsigned shared_tlb_depth;
   } cva6_cfg_t;

   localparam cva6_cfg_t CVA6_CFG_DEFAULT = '{
      xlen: 64, vlen: 64,
      rvf: 1'b1, rvd: 1'b1, rva: 1'b1, rvb: 1'b1, rvv: 1'b0, rvc: 1'b1,
      rvh: 1'b0, rvzcb: 1'b1, rvzcmp: 1'b0, rvzicond: 1'b1, rvs: 1'b1,
      rvu: 1'b1, mmu_present: 1'b1, debug_en: 1'b1,
      icache_byte_size: 16384, icache_set_assoc: 4, icache_line_width: 128,
      dcache_byte_size: 32768, dcache_set_assoc: 8, dcache_line_width: 128,
      nr_pmp_entries: 8, nr_sb_entries: 8, nr_commit_ports: 2,
      nr_load_buf_entries: 2,
      ras_depth: 2, btb_entries: 32, bht_entries: 128,
      itlb_entries: 16, dtlb_entries: 16, shared_tlb_depth: 64
   };

   typedef struct packed {
      logic [63:0]         data;
      logic                err;
      logic [CFG_ID_W-1:0] id;
   } cfg_rsp_t;

   // Returns {data, err} for a static index. The counter slot reads 0 here;
   // the top substitutes the live counter value.
   function automatic logic [64:0] pack_cfg_word(input cva6_cfg_t cfg,
                                                 input int unsigned idx);
      logic [63:0] data;
      logic        err;
      data = '0;
      err  = 1'b0;
      case (idx)
         CFG_IDX_MAGIC:  data = CFG_MAGIC;
         CFG_IDX_LEN:    data = {cfg.vlen, cfg.xlen};
         CFG_IDX_ISA:    data = 64'({cfg.debug_en, cfg.mmu_present, cfg.rvu,
                                     cfg.rvs, cfg.rvzicond, cfg.rvzcmp,
                                     cfg.rvzcb, cfg.rvh, cfg.rvc, cfg.rvv,
                                     cfg.rvb, cfg.rva, cfg.rvd, cfg.rvf});
         CFG_IDX_ICACHE: data = {16'h0, 16'(cfg.icache_byte_size),
                                 16'(cfg.icache_set_assoc),
                                 16'(cfg.icache_line_width)};
         CFG_IDX_DCACHE: data = {16'h0, 16'(cfg.dcache_byte_size),
                                 16'(cfg.dcache_set_assoc),
                                 16'(cfg.dcache_line_width)};
         CFG_IDX_CORE:   data = {16'(cfg.nr_pmp_entries),
                                 16'(cfg.nr_sb_entries),
                                 16'(cfg.nr_commit_ports),
                                 16'(cfg.nr_load_buf_entries)};
         CFG_IDX_BP:     data = {16'h0, 16'(cfg.ras_depth),
                                 16'(cfg.btb_entries),
                                 16'(cfg.bht_entries)};
         CFG_IDX_TLB:    data = {16'h0, 16'(cfg.itlb_entries),
                                 16'(cfg.dtlb_entries),
                                 16'(cfg.shared_tlb_depth)};
         CFG_IDX_CNT:    data = '0;
         default:        err  = 1'b1;
      endcase
      return {data, err};
   endfunction

endpackage

// File: rtl/cfg_rsp_fifo.sv
// Response FIFO: Depth entries of cfg_rsp_t, head read straight from storage,
// push and pop allowed in the same cycle even when full.
// CFG_DISCOVERY_PARITY_EN adds a parity bit stored alongside each entry.
module cfg_rsp_fifo
   import cfg_discovery_pkg::*;
#(
   parameter int unsigned Depth = 2
) (
   input  logic     clk_i,
   input  logic     rst_i,
   input  logic     push_i,
   input  cfg_rsp_t push_data_i,
`ifdef CFG_DISCOVERY_PARITY_EN
   input  logic     push_par_i,
   output logic     head_par_o,
`endif
   input  logic     pop_i,
   output logic     full_o,
   output logic     empty_o,
   output cfg_rsp_t head_o
);

   localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
   localparam int unsigned CntW = $clog2(Depth + 1);

   cfg_rsp_t        mem [Depth];
   logic [PtrW-1:0] rd_ptr;
   logic [PtrW-1:0] wr_ptr;
   logic [CntW-1:0] count;
   logic            push_ok;
   logic            pop_ok;

   function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
      return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
   endfunction

   assign full_o  = (count == CntW'(Depth));
   assign empty_o = (count == '0);
   assign pop_ok  = pop_i & ~empty_o;
   assign push_ok = push_i & (~full_o | pop_ok);
   assign head_o  = mem[rd_ptr];

   // Storage, pointers and occupancy; storage is cleared so the head reads 0 out of reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < Depth; i++) mem[i] <= '0;
      end else begin
         if (push_ok) begin
            mem[wr_ptr] <= push_data_i;
            wr_ptr      <= ptr_inc(wr_ptr);
         end
         if (pop_ok) rd_ptr <= ptr_inc(rd_ptr);
         case ({push_ok, pop_ok})
            2'b10:   count <= count + CntW'(1);
            2'b01:   count <= count - CntW'(1);
            default: count <= count;
         endcase
      end
   end

`ifdef CFG_DISCOVERY_PARITY_EN
   logic par_mem [Depth];

   assign head_par_o = par_mem[rd_ptr];

   // Parity travels with its entry through the same slot.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < Depth; i++) par_mem[i] <= 1'b0;
      end else if (push_ok) begin
         par_mem[wr_ptr] <= push_par_i;
      end
   end
`endif

endmodule

// File: rtl/cfg_discovery_responder.sv
// Read-only responder serving the compiled core configuration over a
// valid/ready request/response port. Responses are queued in cfg_rsp_fifo.
// Optional macro CFG_DISCOVERY_PARITY_EN adds rsp_par_o (even parity over
// {rsp_err_o, rsp_id_o, rsp_data_o}).
module cfg_discovery_responder
   import cfg_discovery_pkg::*;
#(
   parameter cva6_cfg_t   CVA6Cfg   = CVA6_CFG_DEFAULT,
   parameter int unsigned AddrWidth = 4,
   parameter int unsigned IdWidth   = 4,
   parameter int unsigned RspDepth  = 2
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 req_valid_i,
   output logic                 req_ready_o,
   input  logic                 req_we_i,
   input  logic [AddrWidth-1:0] req_addr_i,
   input  logic [IdWidth-1:0]   req_id_i,
   output logic                 rsp_valid_o,
   input  logic                 rsp_ready_i,
   output logic [63:0]          rsp_data_o,
   output logic                 rsp_err_o,
   output logic [IdWidth-1:0]   rsp_id_o
`ifdef CFG_DISCOVERY_PARITY_EN
   ,
   output logic                 rsp_par_o
`endif
);

   logic        fifo_full;
   logic        fifo_empty;
   logic        push;
   logic        pop;
   logic        cnt_inc;
   logic [31:0] req_idx;
   logic [31:0] access_cnt;
   logic [64:0] cfg_word;
   logic        unused_id_bits;
   cfg_rsp_t    push_rsp;
   cfg_rsp_t    head_rsp;

   assign req_idx  = 32'(req_addr_i);
   assign cfg_word = pack_cfg_word(CVA6Cfg, req_idx);

   assign rsp_valid_o = ~fifo_empty;
   assign pop         = rsp_valid_o & rsp_ready_i;
   assign req_ready_o = ~fifo_full | pop;
   assign push        = req_valid_i & req_ready_o;

   // Only successful reads of static words count; counter reads and errors do not.
   assign cnt_inc = push & ~req_we_i & ~cfg_word[0] & (req_idx != CFG_IDX_CNT);

   // Build the response for the request currently on the port.
   always_comb begin
      push_rsp    = '0;
      push_rsp.id = CFG_ID_W'(req_id_i);
      if (req_we_i) begin
         push_rsp.err = 1'b1;
      end else if (req_idx == CFG_IDX_CNT) begin
         push_rsp.data = {32'h0, access_cnt};
      end else begin
         {push_rsp.data, push_rsp.err} = cfg_word;
      end
   end

   // Saturating access counter; a counter read sees the pre-increment value.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         access_cnt <= '0;
      end else if (cnt_inc && (access_cnt != 32'hFFFF_FFFF)) begin
         access_cnt <= access_cnt + 32'd1;
      end
   end

   cfg_rsp_fifo #(
      .Depth (RspDepth)
   ) u_rsp_fifo (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .push_i      (push),
      .push_data_i (push_rsp),
`ifdef CFG_DISCOVERY_PARITY_EN
      .push_par_i  (^{push_rsp.err, req_id_i, push_rsp.data}),
      .head_par_o  (rsp_par_o),
`endif
      .pop_i       (pop),
      .full_o      (fifo_full),
      .empty_o     (fifo_empty),
      .head_o      (head_rsp)
   );

   assign rsp_data_o = head_rsp.data;
   assign rsp_err_o  = head_rsp.err;
   assign rsp_id_o   = head_rsp.id[IdWidth-1:0];

   // Id bits above IdWidth are always written as zero.
   assign unused_id_bits = ^(head_rsp.id >> IdWidth);

endmodule

// File: tb/tb_cfg_discovery_responder.sv
module tb_cfg_discovery_responder;
   import cfg_discovery_pkg::*;

   localparam cva6_cfg_t TB_CFG = '{
      xlen: 64, vlen: 64,
      rvf: 1'b1, rvd: 1'b1, rva: 1'b1, rvb: 1'b0, rvv: 1'b1, rvc: 1'b1,
      rvh: 1'b0, rvzcb: 1'b1, rvzcmp: 1'b0, rvzicond: 1'b1, rvs: 1'b1,
      rvu: 1'b1, mmu_present: 1'b1, debug_en: 1'b0,
      icache_byte_size: 16384, icache_set_assoc: 4, icache_line_width: 128,
      dcache_byte_size: 32'h0001_8000, dcache_set_assoc: 8, dcache_line_width: 128,
      nr_pmp_entries: 8, nr_sb_entries: 8, nr_commit_ports: 2,
      nr_load_buf_entries: 2,
      ras_depth: 2, btb_entries: 32, bht_entries: 128,
      itlb_entries: 16, dtlb_entries: 16, shared_tlb_depth: 64
   };

   localparam logic [63:0] W_MAGIC = 64'hC0F1_6000_0000_0001;
   localparam logic [63:0] W_LEN   = 64'h0000_0040_0000_0040;
   localparam logic [63:0] W_ISA   = 64'h0000_0000_0000_1EB7;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [3:0]  req_addr;
   logic [3:0]  req_id;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [63:0] rsp_data;
   logic        rsp_err;
   logic [3:0]  rsp_id;
`ifdef CFG_DISCOVERY_PARITY_EN
   logic        rsp_par;
`endif

   cfg_discovery_responder #(
      .CVA6Cfg   (TB_CFG),
      .AddrWidth (4),
      .IdWidth   (4),
      .RspDepth  (2)
   ) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .req_valid_i (req_valid),
      .req_ready_o (req_ready),
      .req_we_i    (req_we),
      .req_addr_i  (req_addr),
      .req_id_i    (req_id),
      .rsp_valid_o (rsp_valid),
      .rsp_ready_i (rsp_ready),
      .rsp_data_o  (rsp_data),
      .rsp_err_o   (rsp_err),
`ifdef CFG_DISCOVERY_PARITY_EN
      .rsp_par_o   (rsp_par),
`endif
      .rsp_id_o    (rsp_id)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [63:0] data;
      logic        err;
      logic [3:0]  id;
   } exp_t;

   typedef struct {
      logic        we;
      logic [3:0]  addr;
      logic [3:0]  id;
      logic [63:0] data;
      logic        err;
   } vec_t;

   exp_t exp_q[$];
   int   n_vec = 0;
   int   n_bad = 0;
   vec_t vecs[14];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Drive one request from posedge+1; returns cycles waited before acceptance.
   task automatic send(input logic we, input logic [3:0] addr, input logic [3:0] id,
                       input logic [63:0] ed, input logic ee, output int waited);
      exp_t e;
      bit   ok;
      ok        = 1'b0;
      waited    = 0;
      req_valid = 1'b1;
      req_we    = we;
      req_addr  = addr;
      req_id    = id;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (req_ready) begin
            ok = 1'b1;
            break;
         end
         waited++;
         #1;
      end
      if (ok) begin
         e.data = ed;
         e.err  = ee;
         e.id   = id;
         exp_q.push_back(e);
      end else begin
         n_vec++;
         n_bad++;
         $display("FAIL accept_timeout: id %0d not accepted", id);
      end
      step();
      req_valid = 1'b0;
   endtask

   task automatic drain();
      bit done;
      done = 1'b0;
      for (int c = 0; c < 50; c++) begin
         @(negedge clk);
         #1;
         if (exp_q.size() == 0) begin
            done = 1'b1;
            break;
         end
      end
      if (!done) begin
         n_vec++;
         n_bad++;
         $display("FAIL drain: %0d responses still outstanding", exp_q.size());
      end
      step();
   endtask

   // Scoreboard: every consumed response is matched against the oldest expectation.
   always @(negedge clk) begin
      exp_t e;
      if (!rst && rsp_valid && rsp_ready) begin
         if (exp_q.size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL unexpected_rsp: got id %0d data %h, expected none", rsp_id, rsp_data);
         end else begin
            e = exp_q.pop_front();
            check("rsp_id", 64'(rsp_id), 64'(e.id));
            check("rsp_data", rsp_data, e.data);
            check("rsp_err", 64'(rsp_err), 64'(e.err));
`ifdef CFG_DISCOVERY_PARITY_EN
            check("rsp_par", 64'(rsp_par), 64'(^{e.err, e.id, e.data}));
`endif
         end
      end
   end

   initial begin
      int w;
      int ld;

      vecs[0]  = '{1'b0, 4'd0,  4'd1,  W_MAGIC, 1'b0};
      vecs[1]  = '{1'b0, 4'd2,  4'd2,  W_ISA, 1'b0};
      vecs[2]  = '{1'b0, 4'd3,  4'd3,  64'h0000_4000_0004_0080, 1'b0};
      vecs[3]  = '{1'b0, 4'd4,  4'd4,  64'h0000_8000_0008_0080, 1'b0};
      vecs[4]  = '{1'b0, 4'd5,  4'd5,  64'h0008_0008_0002_0002, 1'b0};
      vecs[5]  = '{1'b0, 4'd6,  4'd6,  64'h0000_0002_0020_0080, 1'b0};
      vecs[6]  = '{1'b0, 4'd7,  4'd7,  64'h0000_0010_0010_0040, 1'b0};
      vecs[7]  = '{1'b1, 4'd0,  4'd8,  64'h0, 1'b1};
      vecs[8]  = '{1'b0, 4'd12, 4'd9,  64'h0, 1'b1};
      vecs[9]  = '{1'b0, 4'd9,  4'd10, 64'h0, 1'b1};
      vecs[10] = '{1'b1, 4'd8,  4'd11, 64'h0, 1'b1};
      vecs[11] = '{1'b0, 4'd15, 4'd12, 64'h0, 1'b1};
      vecs[12] = '{1'b0, 4'd1,  4'd13, W_LEN, 1'b0};
      vecs[13] = '{1'b1, 4'd3,  4'd14, 64'h0, 1'b1};

      rst       = 1'b1;
      req_valid = 1'b0;
      req_we    = 1'b0;
      req_addr  = '0;
      req_id    = '0;
      rsp_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;

      @(negedge clk);
      check("reset_rsp_valid", 64'(rsp_valid), 64'd0);
      check("reset_rsp_data", rsp_data, 64'd0);
      check("reset_rsp_err", 64'(rsp_err), 64'd0);
      check("reset_rsp_id", 64'(rsp_id), 64'd0);
      check("reset_req_ready", 64'(req_ready), 64'd1);
`ifdef CFG_DISCOVERY_PARITY_EN
      check("reset_rsp_par", 64'(rsp_par), 64'd0);
`endif
      step();

      // First read: entry must not bypass the FIFO, then appears one cycle later.
      req_valid = 1'b1;
      req_we    = 1'b0;
      req_addr  = 4'd1;
      req_id    = 4'd3;
      @(negedge clk);
      check("lat_accept", 64'(req_ready), 64'd1);
      check("lat_no_bypass", 64'(rsp_valid), 64'd0);
      exp_q.push_back(exp_t'{data: W_LEN, err: 1'b0, id: 4'd3});
      step();
      req_valid = 1'b0;
      @(negedge clk);
      check("lat_rsp_valid", 64'(rsp_valid), 64'd1);
      step();

      // Table sweep, back to back with the response side always ready.
      for (int i = 0; i < 14; i++) begin
         send(vecs[i].we, vecs[i].addr, vecs[i].id, vecs[i].data, vecs[i].err, w);
         check("throughput_wait", 64'(w), 64'd0);
      end
      drain();

      // Back-pressure: two fill the FIFO, the third waits until a pop frees a slot.
      rsp_ready = 1'b0;
      send(1'b0, 4'd1, 4'd5, W_LEN, 1'b0, w);
      send(1'b0, 4'd0, 4'd6, W_MAGIC, 1'b0, w);
      req_valid = 1'b1;
      req_we    = 1'b0;
      req_addr  = 4'd2;
      req_id    = 4'd7;
      @(negedge clk);
      check("bp_ready_low", 64'(req_ready), 64'd0);
      check("bp_head_id", 64'(rsp_id), 64'd5);
      step();
      @(negedge clk);
      check("bp_ready_still_low", 64'(req_ready), 64'd0);
      check("bp_stable_id", 64'(rsp_id), 64'd5);
      check("bp_stable_data", rsp_data, W_LEN);
      step();
      rsp_ready = 1'b1;
      send(1'b0, 4'd2, 4'd7, W_ISA, 1'b0, w);
      check("bp_same_cycle_accept", 64'(w), 64'd0);
      drain();

      // Reset with two queued responses: they must vanish and the counter clears.
      rsp_ready = 1'b0;
      send(1'b0, 4'd0, 4'd1, W_MAGIC, 1'b0, w);
      send(1'b0, 4'd0, 4'd2, W_MAGIC, 1'b0, w);
      rst = 1'b1;
      step();
      exp_q.delete();
      rsp_ready = 1'b1;
      @(negedge clk);
      check("rst_mid_valid", 64'(rsp_valid), 64'd0);
      check("rst_mid_ready", 64'(req_ready), 64'd1);
      step();
      rst = 1'b0;
      send(1'b0, 4'd8, 4'd3, 64'd0, 1'b0, w);

      // Counter: five magic reads, then read back.
      for (int i = 0; i < 5; i++) send(1'b0, 4'd0, 4'(i), W_MAGIC, 1'b0, w);
      send(1'b0, 4'd8, 4'd9, 64'd5, 1'b0, w);
      drain();

      // Saturation.
      force dut.access_cnt = 32'hFFFF_FFFE;
      step();
      release dut.access_cnt;
      send(1'b0, 4'd8, 4'd1, 64'h0000_0000_FFFF_FFFE, 1'b0, w);
      send(1'b0, 4'd0, 4'd2, W_MAGIC, 1'b0, w);
      send(1'b0, 4'd8, 4'd3, 64'h0000_0000_FFFF_FFFF, 1'b0, w);
      send(1'b0, 4'd0, 4'd4, W_MAGIC, 1'b0, w);
      send(1'b0, 4'd0, 4'd5, W_MAGIC, 1'b0, w);
      send(1'b0, 4'd8, 4'd6, 64'h0000_0000_FFFF_FFFF, 1'b0, w);
      drain();

      ld = exp_q.size();
      check("final_queue_empty", 64'(ld), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
